rom_scan_tester: RTL and testbench
==================================

Name: rom_scan_tester

Overview:
- Parametrised ROM test engine: drives a synchronous ROM's read port, either for a single read or a full-depth sequential scan.
- A scan reduces the data to a sum, an XOR signature, or a mismatch count against an identity pattern.
- Sits between the tile's pin mux and the ROM macro under test. Replaces the bare ROM test tile with configurable width, depth, read latency and check mode.

Parameters:
- DATA_W, 8, ROM word width (1..32).
- ADDR_W, 8, ROM address width; DEPTH = 2**ADDR_W words are scanned.
- READ_LAT, 1, cycles from rom_en/rom_addr to valid rom_data (1..4).

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin operation; sampled only when busy=0.
- abort  in  1  cancel current operation.
- mode  in  2  00 single read, 01 scan-sum, 10 scan-xor, 11 scan-identity.
- addr_in  in  ADDR_W  address for single read.
- expected  in  DATA_W  reference for pass in modes 01/10.
- rom_en  out  1  ROM read enable.
- rom_addr  out  ADDR_W  ROM address.
- rom_data  in  DATA_W  ROM read data.
- rd_valid  out  1  rd_data carries a returned word this cycle.
- rd_data  out  DATA_W  returned word, streamed for external dump.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- pass  out  1  check result, held until next start.
- result  out  DATA_W  single-read data / sum / xor / mismatch count, held until next start.

Behaviour:
- Reset (async, rst=1): all outputs 0; state IDLE; valid pipeline cleared; mode latch 00.
- States: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start=1 latches mode, addr_in and expected.
  - Clears result and pass; sets busy.
  - Goes to ISSUE.
- ISSUE:
  - rom_en=1 each cycle. rom_addr = addr_in (single) or counter 0..DEPTH-1, one address per cycle with no gaps.
  - Leaves for DRAIN after the last address (1 cycle for single, DEPTH cycles for scan).
  - Counter does not wrap; it stops at DEPTH-1.
- Valid pipeline: a READ_LAT-deep shift register tracks issued reads.
  - rom_data is captured on the edge ending cycle (issue cycle + READ_LAT).
  - rd_valid and rd_data are registered and present in the following cycle.
- Accumulation on each captured word:
  - Single: result = word.
  - 01: result = result + word, mod 2**DATA_W.
  - 10: result = result ^ word.
  - 11: result = result + 1 if word != rom_addr-of-that-word zero-extended/truncated to DATA_W; saturates at 2**DATA_W-1.
- DRAIN: waits until the valid pipeline is empty, then goes to DONE.
- DONE:
  - done=1 for exactly one cycle; busy=0 in the same cycle.
  - pass: single -> 1; 01/10 -> result==expected; 11 -> result==0.
  - Returns to IDLE.
- Timing, with start high in cycle 0:
  - Scan: rom_en high in cycles 1..DEPTH; done in cycle DEPTH+READ_LAT+1.
  - Single: done in cycle READ_LAT+2.
- start while busy=1: ignored, with no effect on latched mode or address.
- start in the DONE cycle: ignored; a new start is accepted from the next cycle.
- abort=1 in any non-IDLE state:
  - Next state IDLE; rom_en drops immediately (combinational gate) and busy drops next cycle.
  - Valid pipeline flushed, so in-flight data is discarded and no rd_valid follows.
  - done not pulsed; pass=0; result keeps its partial value.
- abort and start in the same cycle while IDLE: abort wins, start ignored.
- rst asserted mid-operation: immediate return to reset values; no done pulse.

Test Plan:
- ROM model word[a]=a^8'h5A for every test below; DATA_W=8, ADDR_W=4, READ_LAT=2 unless stated.
- Single read: mode=00, addr_in=3, start in cycle 0 -> rom_en only in cycle 1 with rom_addr=3; rd_valid with rd_data=8'h59 in cycle 4; done in cycle 4; result=8'h59, pass=1.
- Scan-sum: mode=01, expected=8'h78 -> rom_en cycles 1..16 with addresses 0..15; 16 rd_valid pulses; done in cycle 19; result=8'h78, pass=1. Rerun with expected=8'h77 -> pass=0.
- Scan-xor and identity:
  - mode=10, expected=0 -> result=8'h00, pass=1.
  - mode=11 -> result=8'h10, pass=0.
  - mode=11 with word[a]=a -> result=0, pass=1.
- Abort and ignored start: mode=01, abort in cycle 8 -> no done; busy=0 by cycle 9; no rd_valid after cycle 9. Separately, start pulsed in cycle 5 of a scan -> the scan is unchanged and done still occurs in cycle 19.
- Latency sweep: READ_LAT=1 and 4, mode=01 -> done in cycles 18 and 21; result=8'h78 in both.
- Async reset: rst asserted mid-scan between clock edges -> all outputs 0 immediately. After release, start works normally.

Source files
------------

// File: rtl/rom_scan_tester.sv
// rtl/rom_scan_tester.sv - ROM read/scan test engine with sum, xor and identity checks
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   start              begin an operation, accepted only while idle
//   abort              cancel the current operation
//   mode               00 single read, 01 scan-sum, 10 scan-xor, 11 scan-identity
//   addr_in            address used by a single read
//   expected           reference value compared against result in modes 01/10
//   rom_en, rom_addr   ROM read request
//   rom_data           ROM read data, valid READ_LAT cycles after the request
//   rd_valid, rd_data  stream of returned words for external dump
//   busy               operation in progress
//   done               one-cycle completion pulse
//   pass, result       check outcome and accumulated value, held until next start
module rom_scan_tester #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] expected,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [DATA_W-1:0] result
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam int EXT_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;

  localparam logic [1:0] M_SINGLE = 2'b00;
  localparam logic [1:0] M_SUM    = 2'b01;
  localparam logic [1:0] M_XOR    = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state;
  logic [1:0]          mode_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic [DATA_W-1:0]   expected_q;
  logic                issue_q;

  // One stage per cycle of ROM latency; the top stage marks the cycle in
  // which rom_data belongs to an issued read. The address rides along so the
  // identity check can compare each word against its own address.
  logic [READ_LAT-1:0] vld_pipe;
  logic [ADDR_W-1:0]   addr_pipe [READ_LAT];

  logic                cap_vld;
  logic [ADDR_W-1:0]   cap_addr;
  logic [EXT_W-1:0]    cap_addr_wide;
  logic [DATA_W-1:0]   cap_addr_ext;
  logic [READ_LAT-1:0] vld_upper;
  logic [DATA_W-1:0]   acc_next;
  logic [DATA_W-1:0]   final_result;
  logic                pass_next;

  // abort must stop ROM traffic in the very cycle it is raised
  assign rom_en   = issue_q & ~abort;
  assign rom_addr = issue_q ? ((mode_q == M_SINGLE) ? addr_q : cnt_q) : '0;

  assign cap_vld       = vld_pipe[READ_LAT-1];
  assign cap_addr      = addr_pipe[READ_LAT-1];
  assign cap_addr_wide = EXT_W'(cap_addr);
  assign cap_addr_ext  = cap_addr_wide[DATA_W-1:0];

  // Stages below the top one: when all clear, the word completing this cycle
  // is the last one in flight.
  assign vld_upper = vld_pipe << 1;

  always_comb begin
    acc_next = result;
    case (mode_q)
      M_SINGLE: acc_next = rom_data;
      M_SUM:    acc_next = result + rom_data;
      M_XOR:    acc_next = result ^ rom_data;
      default: begin
        // mismatch counter saturates instead of wrapping back to a "clean" 0
        if ((rom_data != cap_addr_ext) && (result != '1)) begin
          acc_next = result + DATA_W'(1);
        end
      end
    endcase
  end

  // Pass is decided on the edge entering DONE, so it must see the value the
  // last captured word is about to produce.
  always_comb begin
    final_result = cap_vld ? acc_next : result;
    pass_next    = 1'b0;
    case (mode_q)
      M_SINGLE:      pass_next = 1'b1;
      M_SUM, M_XOR:  pass_next = (final_result == expected_q);
      default:       pass_next = (final_result == '0);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      mode_q     <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      expected_q <= '0;
      issue_q    <= 1'b0;
      vld_pipe   <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        addr_pipe[i] <= '0;
      end
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      result     <= '0;
    end else begin
      for (int i = READ_LAT - 1; i > 0; i--) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
      vld_pipe[0]  <= rom_en;
      addr_pipe[0] <= rom_addr;
      rd_valid     <= 1'b0;
      done         <= 1'b0;

      if (abort && (state != S_IDLE)) begin
        // in-flight reads are dropped; result keeps its partial value
        state    <= S_IDLE;
        issue_q  <= 1'b0;
        busy     <= 1'b0;
        pass     <= 1'b0;
        vld_pipe <= '0;
      end else begin
        if (cap_vld) begin
          rd_valid <= 1'b1;
          rd_data  <= rom_data;
          result   <= acc_next;
        end

        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              mode_q     <= mode;
              addr_q     <= addr_in;
              expected_q <= expected;
              cnt_q      <= '0;
              result     <= '0;
              pass       <= 1'b0;
              busy       <= 1'b1;
              issue_q    <= 1'b1;
              state      <= S_ISSUE;
            end
          end

          S_ISSUE: begin
            if ((mode_q == M_SINGLE) || (cnt_q == LAST_ADDR)) begin
              issue_q <= 1'b0;
              state   <= S_DRAIN;
            end else begin
              cnt_q <= cnt_q + ADDR_W'(1);
            end
          end

          S_DRAIN: begin
            if (vld_upper == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
              pass  <= pass_next;
            end
          end

          default: begin
            // start during the DONE cycle is deliberately not looked at
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_scan_tester.sv
// tb/tb_rom_scan_tester.sv - testbench for rom_scan_tester at read latencies 1, 2 and 4
module tb_rom_scan_tester;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [1:0] mode;
  logic [3:0] addr_in;
  logic [7:0] expected;

  logic       rom_en_w   [3];
  logic [3:0] rom_addr_w [3];
  logic [7:0] rom_data_w [3];
  logic       rd_valid_w [3];
  logic [7:0] rd_data_w  [3];
  logic       busy_w     [3];
  logic       done_w     [3];
  logic       pass_w     [3];
  logic [7:0] result_w   [3];

  logic [7:0] mem   [DEPTH];
  logic [7:0] rpipe [3][4];

  int n_checks = 0;
  int n_fail   = 0;

  int         en_cnt [3];
  int         en_first [3];
  int         en_last [3];
  int         addr_err [3];
  int         rv_cnt [3];
  int         rv_last [3];
  int         rd_err [3];
  int         done_cyc [3];
  int         done_cnt [3];
  logic [7:0] res_done [3];
  logic       pass_done [3];
  logic       busy_probe [3];

  always #5 clk = ~clk;

  // behavioural synchronous ROM: a word requested in cycle t appears in cycle t+L
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      rpipe[k][0] <= rom_en_w[k] ? mem[rom_addr_w[k]] : 8'h00;
      for (int i = 1; i < 4; i++) rpipe[k][i] <= rpipe[k][i-1];
    end
  end
  assign rom_data_w[0] = rpipe[0][0];
  assign rom_data_w[1] = rpipe[1][1];
  assign rom_data_w[2] = rpipe[2][3];

  rom_scan_tester #(.DATA_W(8), .ADDR_W(4), .READ_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .addr_in(addr_in),
    .expected(expected), .rom_en(rom_en_w[0]), .rom_addr(rom_addr_w[0]), .rom_data(rom_data_w[0]),
    .rd_valid(rd_valid_w[0]), .rd_data(rd_data_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .pass(pass_w[0]), .result(result_w[0]));

  rom_scan_tester #(.DATA_W(8), .ADDR_W(4), .READ_LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .addr_in(addr_in),
    .expected(expected), .rom_en(rom_en_w[1]), .rom_addr(rom_addr_w[1]), .rom_data(rom_data_w[1]),
    .rd_valid(rd_valid_w[1]), .rd_data(rd_data_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .pass(pass_w[1]), .result(result_w[1]));

  rom_scan_tester #(.DATA_W(8), .ADDR_W(4), .READ_LAT(4)) u_lat4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .addr_in(addr_in),
    .expected(expected), .rom_en(rom_en_w[2]), .rom_addr(rom_addr_w[2]), .rom_data(rom_data_w[2]),
    .rd_valid(rd_valid_w[2]), .rd_data(rd_data_w[2]), .busy(busy_w[2]), .done(done_w[2]),
    .pass(pass_w[2]), .result(result_w[2]));

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  function automatic int model_done(input logic [1:0] m, input int k);
    return (m == 2'b00) ? lat_of(k) + 2 : DEPTH + lat_of(k) + 1;
  endfunction

  // reduction over the first n words of the ROM (or the single addressed word)
  function automatic logic [7:0] model_result(input logic [1:0] m, input logic [3:0] a, input int n);
    int acc = 0;
    if (m == 2'b00) return mem[a];
    for (int i = 0; i < n; i++) begin
      case (m)
        2'b01:   acc = (acc + int'(mem[i])) % 256;
        2'b10:   acc = acc ^ int'(mem[i]);
        default: if (mem[i] != 8'(i)) acc = (acc < 255) ? acc + 1 : 255;
      endcase
    end
    return 8'(acc);
  endfunction

  function automatic logic model_pass(input logic [1:0] m, input logic [7:0] r, input logic [7:0] e);
    if (m == 2'b00) return 1'b1;
    if (m == 2'b11) return (r == 8'h00);
    return (r == e);
  endfunction

  function automatic logic [24:0] outs(input int k);
    return {rom_en_w[k], rom_addr_w[k], rd_valid_w[k], rd_data_w[k], busy_w[k], done_w[k], pass_w[k], result_w[k]};
  endfunction

  // Entered just after a rising edge; that cycle is cycle 0 with start high.
  task automatic run_op(input logic [1:0] m, input logic [3:0] a, input logic [7:0] e,
                        input int abort_cyc, input int start2_cyc, input int probe_cyc, input int ncyc);
    logic [3:0] exp_a;
    logic [7:0] exp_d;
    for (int k = 0; k < 3; k++) begin
      en_cnt[k] = 0; en_first[k] = -1; en_last[k] = -1; addr_err[k] = 0; rv_cnt[k] = 0;
      rv_last[k] = -1; rd_err[k] = 0; done_cyc[k] = -1; done_cnt[k] = 0; res_done[k] = 8'h00;
      pass_done[k] = 1'b0; busy_probe[k] = 1'b0;
    end
    mode = m; addr_in = a; expected = e;
    for (int c = 0; c < ncyc; c++) begin
      start = (c == 0) || (c == start2_cyc);
      abort = (c == abort_cyc);
      if (c == start2_cyc) begin mode = ~m; addr_in = ~a; expected = ~e; end
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (rom_en_w[k]) begin
          en_cnt[k]++;
          if (en_first[k] < 0) en_first[k] = c;
          en_last[k] = c;
          exp_a = (m == 2'b00) ? a : 4'(c - 1);
          if (rom_addr_w[k] !== exp_a) addr_err[k]++;
        end
        if (rd_valid_w[k]) begin
          exp_d = (m == 2'b00) ? mem[a] : mem[rv_cnt[k][3:0]];
          if (rd_data_w[k] !== exp_d) rd_err[k]++;
          rv_cnt[k]++;
          rv_last[k] = c;
        end
        if (done_w[k]) begin
          done_cnt[k]++;
          if (done_cyc[k] < 0) done_cyc[k] = c;
          res_done[k] = result_w[k];
          pass_done[k] = pass_w[k];
        end
        if (c == probe_cyc) busy_probe[k] = busy_w[k];
      end
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i) ^ 8'h5A;
  endtask

  task automatic test_reset();
    logic [24:0] v;
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'b00; addr_in = 4'h0; expected = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      v = outs(k);
      n_checks++; if (v !== 25'd0) begin n_fail++; $display("FAIL reset_outputs inst%0d: got %h expected 0", k, v); end
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [7:0] r;
    fill_pattern();
    run_op(2'b00, 4'd3, 8'h00, -1, -1, -1, 10);
    r = model_result(2'b00, 4'd3, 1);
    n_checks++; if (res_done[1] !== 8'h59) begin n_fail++; $display("FAIL single_result_value: got %h expected 59", res_done[1]); end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (en_cnt[k] !== 1) begin n_fail++; $display("FAIL single_en_cnt inst%0d: got %0d expected 1", k, en_cnt[k]); end
      n_checks++; if (en_first[k] !== 1) begin n_fail++; $display("FAIL single_en_cycle inst%0d: got %0d expected 1", k, en_first[k]); end
      n_checks++; if (addr_err[k] !== 0) begin n_fail++; $display("FAIL single_addr inst%0d: got %0d bad expected 0", k, addr_err[k]); end
      n_checks++; if (rv_cnt[k] !== 1) begin n_fail++; $display("FAIL single_rv_cnt inst%0d: got %0d expected 1", k, rv_cnt[k]); end
      n_checks++; if (rv_last[k] !== lat_of(k) + 2) begin n_fail++; $display("FAIL single_rv_cycle inst%0d: got %0d expected %0d", k, rv_last[k], lat_of(k) + 2); end
      n_checks++; if (rd_err[k] !== 0) begin n_fail++; $display("FAIL single_rd_data inst%0d: got %0d bad expected 0", k, rd_err[k]); end
      n_checks++; if (done_cyc[k] !== model_done(2'b00, k)) begin n_fail++; $display("FAIL single_done_cycle inst%0d: got %0d expected %0d", k, done_cyc[k], model_done(2'b00, k)); end
      n_checks++; if (res_done[k] !== r) begin n_fail++; $display("FAIL single_result inst%0d: got %h expected %h", k, res_done[k], r); end
      n_checks++; if (pass_done[k] !== 1'b1) begin n_fail++; $display("FAIL single_pass inst%0d: got %b expected 1", k, pass_done[k]); end
    end
  endtask

  task automatic test_scan_sum();
    logic [7:0] r;
    fill_pattern();
    r = model_result(2'b01, 4'd0, DEPTH);
    run_op(2'b01, 4'd0, 8'h78, -1, -1, -1, 23);
    n_checks++; if (done_cyc[1] !== 19) begin n_fail++; $display("FAIL sum_done_cycle_lat2: got %0d expected 19", done_cyc[1]); end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (en_cnt[k] !== DEPTH) begin n_fail++; $display("FAIL sum_en_cnt inst%0d: got %0d expected 16", k, en_cnt[k]); end
      n_checks++; if (en_first[k] !== 1 || en_last[k] !== DEPTH) begin n_fail++; $display("FAIL sum_en_window inst%0d: got %0d..%0d expected 1..16", k, en_first[k], en_last[k]); end
      n_checks++; if (addr_err[k] !== 0) begin n_fail++; $display("FAIL sum_addr inst%0d: got %0d bad expected 0", k, addr_err[k]); end
      n_checks++; if (rv_cnt[k] !== DEPTH) begin n_fail++; $display("FAIL sum_rv_cnt inst%0d: got %0d expected 16", k, rv_cnt[k]); end
      n_checks++; if (rd_err[k] !== 0) begin n_fail++; $display("FAIL sum_rd_data inst%0d: got %0d bad expected 0", k, rd_err[k]); end
      n_checks++; if (done_cyc[k] !== model_done(2'b01, k)) begin n_fail++; $display("FAIL sum_done_cycle inst%0d: got %0d expected %0d", k, done_cyc[k], model_done(2'b01, k)); end
      n_checks++; if (res_done[k] !== r) begin n_fail++; $display("FAIL sum_result inst%0d: got %h expected %h", k, res_done[k], r); end
      n_checks++; if (pass_done[k] !== 1'b1) begin n_fail++; $display("FAIL sum_pass inst%0d: got %b expected 1", k, pass_done[k]); end
    end
    run_op(2'b01, 4'd0, 8'h77, -1, -1, -1, 23);
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (res_done[k] !== r) begin n_fail++; $display("FAIL sum_bad_result inst%0d: got %h expected %h", k, res_done[k], r); end
      n_checks++; if (pass_done[k] !== 1'b0) begin n_fail++; $display("FAIL sum_bad_pass inst%0d: got %b expected 0", k, pass_done[k]); end
      n_checks++; if (pass_w[k] !== 1'b0 || result_w[k] !== r) begin n_fail++; $display("FAIL sum_hold inst%0d: got %b/%h expected 0/%h", k, pass_w[k], result_w[k], r); end
    end
  endtask

  task automatic test_scan_xor_identity();
    logic [7:0] r;
    fill_pattern();
    r = model_result(2'b10, 4'd0, DEPTH);
    run_op(2'b10, 4'd0, 8'h00, -1, -1, -1, 23);
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (res_done[k] !== r || pass_done[k] !== 1'b1) begin n_fail++; $display("FAIL xor_check inst%0d: got %h/%b expected %h/1", k, res_done[k], pass_done[k], r); end
    end
    r = model_result(2'b11, 4'd0, DEPTH);
    run_op(2'b11, 4'd0, 8'h00, -1, -1, -1, 23);
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (res_done[k] !== r || pass_done[k] !== 1'b0) begin n_fail++; $display("FAIL ident_bad inst%0d: got %h/%b expected %h/0", k, res_done[k], pass_done[k], r); end
    end
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
    run_op(2'b11, 4'd0, 8'h00, -1, -1, -1, 23);
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (res_done[k] !== 8'h00 || pass_done[k] !== 1'b1) begin n_fail++; $display("FAIL ident_good inst%0d: got %h/%b expected 00/1", k, res_done[k], pass_done[k]); end
    end
    fill_pattern();
  endtask

  task automatic test_abort();
    int n;
    logic [7:0] r;
    fill_pattern();
    run_op(2'b01, 4'd0, 8'h78, 8, -1, 9, 14);
    for (int k = 0; k < 3; k++) begin
      // words returned in cycles up to the abort cycle survive; later ones are flushed
      n = 8 - lat_of(k) - 1;
      r = model_result(2'b01, 4'd0, n);
      n_checks++; if (done_cnt[k] !== 0) begin n_fail++; $display("FAIL abort_no_done inst%0d: got %0d expected 0", k, done_cnt[k]); end
      n_checks++; if (busy_probe[k] !== 1'b0) begin n_fail++; $display("FAIL abort_busy inst%0d: got %b expected 0", k, busy_probe[k]); end
      n_checks++; if (en_last[k] !== 7) begin n_fail++; $display("FAIL abort_rom_en inst%0d: got %0d expected 7", k, en_last[k]); end
      n_checks++; if (rv_cnt[k] !== n || rv_last[k] > 9) begin n_fail++; $display("FAIL abort_rv inst%0d: got %0d ending %0d expected %0d", k, rv_cnt[k], rv_last[k], n); end
      n_checks++; if (result_w[k] !== r || pass_w[k] !== 1'b0) begin n_fail++; $display("FAIL abort_partial inst%0d: got %h/%b expected %h/0", k, result_w[k], pass_w[k], r); end
    end
  endtask

  task automatic test_start_ignored();
    logic [7:0] r;
    fill_pattern();
    r = model_result(2'b01, 4'd0, DEPTH);
    run_op(2'b01, 4'd0, 8'h78, -1, 5, -1, 23);
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (done_cyc[k] !== model_done(2'b01, k)) begin n_fail++; $display("FAIL busy_start_done inst%0d: got %0d expected %0d", k, done_cyc[k], model_done(2'b01, k)); end
      n_checks++; if (en_cnt[k] !== DEPTH || addr_err[k] !== 0) begin n_fail++; $display("FAIL busy_start_addr inst%0d: got %0d reads %0d bad expected 16/0", k, en_cnt[k], addr_err[k]); end
      n_checks++; if (res_done[k] !== r || pass_done[k] !== 1'b1) begin n_fail++; $display("FAIL busy_start_result inst%0d: got %h/%b expected %h/1", k, res_done[k], pass_done[k], r); end
    end
  endtask

  task automatic test_abort_start_idle();
    run_op(2'b01, 4'd0, 8'h78, 0, -1, 1, 4);
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (busy_probe[k] !== 1'b0 || en_cnt[k] !== 0) begin n_fail++; $display("FAIL abort_wins inst%0d: got busy %b reads %0d expected 0/0", k, busy_probe[k], en_cnt[k]); end
    end
  endtask

  task automatic test_start_in_done();
    fill_pattern();
    // start pulsed in cycle 19: the DONE cycle of latency 2, the first idle cycle of latency 1
    run_op(2'b01, 4'd0, 8'h78, -1, 19, 20, 22);
    n_checks++; if (done_cnt[1] !== 1 || busy_probe[1] !== 1'b0) begin n_fail++; $display("FAIL start_in_done lat2: got done %0d busy %b expected 1/0", done_cnt[1], busy_probe[1]); end
    n_checks++; if (busy_probe[0] !== 1'b1) begin n_fail++; $display("FAIL start_after_done lat1: got busy %b expected 1", busy_probe[0]); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [24:0] v;
    fill_pattern();
    run_op(2'b01, 4'd0, 8'h78, -1, -1, -1, 8);
    #3;
    n_checks++; if (busy_w[1] !== 1'b1) begin n_fail++; $display("FAIL async_pre_busy: got %b expected 1", busy_w[1]); end
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      v = outs(k);
      n_checks++; if (v !== 25'd0) begin n_fail++; $display("FAIL async_reset_outputs inst%0d: got %h expected 0", k, v); end
    end
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(2'b00, 4'd9, 8'h00, -1, -1, -1, 10);
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (done_cnt[k] !== 1 || done_cyc[k] !== model_done(2'b00, k)) begin n_fail++; $display("FAIL post_reset_done inst%0d: got %0d at %0d expected 1 at %0d", k, done_cnt[k], done_cyc[k], model_done(2'b00, k)); end
      n_checks++; if (res_done[k] !== mem[9] || pass_done[k] !== 1'b1) begin n_fail++; $display("FAIL post_reset_result inst%0d: got %h/%b expected %h/1", k, res_done[k], pass_done[k], mem[9]); end
    end
  endtask

  task automatic test_random();
    logic [1:0] m;
    logic [3:0] a;
    logic [7:0] e;
    logic [7:0] r;
    int sel;
    int nrv;
    for (int it = 0; it < 10; it++) begin
      sel = $urandom_range(0, 2);
      for (int i = 0; i < DEPTH; i++) mem[i] = (sel == 0) ? 8'(i) : 8'($urandom);
      m = 2'($urandom_range(0, 3));
      a = 4'($urandom);
      r = model_result(m, a, DEPTH);
      e = ($urandom_range(0, 1) == 1) ? r : 8'($urandom);
      nrv = (m == 2'b00) ? 1 : DEPTH;
      run_op(m, a, e, -1, -1, -1, 23);
      for (int k = 0; k < 3; k++) begin
        n_checks++; if (done_cyc[k] !== model_done(m, k)) begin n_fail++; $display("FAIL rand_done it%0d inst%0d mode %0d: got %0d expected %0d", it, k, m, done_cyc[k], model_done(m, k)); end
        n_checks++; if (res_done[k] !== r) begin n_fail++; $display("FAIL rand_result it%0d inst%0d mode %0d: got %h expected %h", it, k, m, res_done[k], r); end
        n_checks++; if (pass_done[k] !== model_pass(m, r, e)) begin n_fail++; $display("FAIL rand_pass it%0d inst%0d mode %0d: got %b expected %b", it, k, m, pass_done[k], model_pass(m, r, e)); end
        n_checks++; if (rv_cnt[k] !== nrv || rd_err[k] !== 0 || addr_err[k] !== 0) begin n_fail++; $display("FAIL rand_stream it%0d inst%0d: got %0d words %0d/%0d bad expected %0d 0/0", it, k, rv_cnt[k], rd_err[k], addr_err[k], nrv); end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    fill_pattern();
    test_reset();
    test_single();
    test_scan_sum();
    test_scan_xor_identity();
    test_abort();
    test_start_ignored();
    test_abort_start_idle();
    test_start_in_done();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
